// File: rtl/cnt_pkg.sv
// Shared types and constants for the counter peripheral datapath.
package cnt_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2
    } cnt_state_e;

    localparam int unsigned CntDefaultWidth = 32;

endpackage : cnt_pkg

// File: rtl/cnt_prescaler.sv
// Divides enabled cycles by PRESCALE; tick marks the cycle the counter advances.
module cnt_prescaler
    import cnt_pkg::*;
#(
    parameter int unsigned PRESCALE = 1
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] pre_q;

    // With PRESCALE=1 the register never leaves 0, so tick reduces to en.
    assign tick = en && (pre_q == LAST);

    always_ff @(posedge clk_i) begin
        if (!rst_ni || clr) begin
            pre_q <= '0;
        end else if (en) begin
            pre_q <= tick ? '0 : pre_q + PW'(1);
        end
    end

endmodule : cnt_prescaler

// File: rtl/cnt_core.sv
// Counter datapath: prescaled count up to a threshold, sticky terminal count
// and a one-cycle interrupt on its rising edge.
module cnt_core
    import cnt_pkg::*;
#(
    parameter int unsigned WIDTH    = CntDefaultWidth,
    parameter int unsigned PRESCALE = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             cnt_en_i,
    input  logic             cnt_clr_i,
    input  logic [WIDTH-1:0] cnt_thr_i,
    output logic             cnt_tc_o,
    output logic             cnt_irq_o,
    output logic [WIDTH-1:0] cnt_val_o
);

    cnt_state_e       state_q, state_d;
    logic [WIDTH-1:0] cnt_val_q;
    logic             tc_q;
    logic             irq_q;
    logic             detect;
    logic             inc_en;
    logic             tick;

    // Detect wins over a simultaneous enable drop; the count can never pass
    // the threshold, so saturation at all-ones is implied by the compare.
    always_comb begin
        state_d = state_q;
        detect  = 1'b0;
        inc_en  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (cnt_en_i) state_d = COUNT;
            end
            COUNT: begin
                if (cnt_val_q >= cnt_thr_i) begin
                    detect  = 1'b1;
                    state_d = DONE;
                end else if (!cnt_en_i) begin
                    state_d = IDLE;
                end else begin
                    inc_en = 1'b1;
                end
            end
            DONE: begin
                state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
        if (cnt_clr_i) begin
            state_d = IDLE;
            detect  = 1'b0;
            inc_en  = 1'b0;
        end
    end

    cnt_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .en     (inc_en),
        .clr    (cnt_clr_i),
        .tick   (tick)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            cnt_val_q <= '0;
            tc_q      <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            irq_q   <= detect;
            if (cnt_clr_i) begin
                cnt_val_q <= '0;
                tc_q      <= 1'b0;
            end else begin
                if (detect) tc_q <= 1'b1;
                if (tick)   cnt_val_q <= cnt_val_q + WIDTH'(1);
            end
        end
    end

    assign cnt_tc_o  = tc_q;
    assign cnt_irq_o = irq_q;
    assign cnt_val_o = cnt_val_q;

endmodule : cnt_core

// File: tb/tb_cnt_core.sv
// Bench for cnt_core: two instances (WIDTH=4/PRESCALE=1, WIDTH=8/PRESCALE=4)
// driven in lockstep and compared every cycle against a tick-accumulator model.
module tb_cnt_core;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic       clr = 1'b0;
    logic [3:0] thr_a = '0;
    logic [7:0] thr_b = '0;
    logic       tc_a, irq_a, tc_b, irq_b;
    logic [3:0] val_a;
    logic [7:0] val_b;

    int n_cmp = 0;
    int n_err = 0;

    // Model: ticks = count*P + prescaler phase, so count = ticks / P.
    int m_ticks [2];
    int m_run   [2];
    int m_tc    [2];
    int m_irq   [2];
    int m_p     [2] = '{1, 4};

    always #5 clk = ~clk;

    cnt_core #(.WIDTH(4), .PRESCALE(1)) u_a (
        .clk_i(clk), .rst_ni(rst_n), .cnt_en_i(en), .cnt_clr_i(clr),
        .cnt_thr_i(thr_a), .cnt_tc_o(tc_a), .cnt_irq_o(irq_a), .cnt_val_o(val_a)
    );

    cnt_core #(.WIDTH(8), .PRESCALE(4)) u_b (
        .clk_i(clk), .rst_ni(rst_n), .cnt_en_i(en), .cnt_clr_i(clr),
        .cnt_thr_i(thr_b), .cnt_tc_o(tc_b), .cnt_irq_o(irq_b), .cnt_val_o(val_b)
    );

    task automatic check_eq(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge();
        for (int k = 0; k < 2; k++) begin
            int thr;
            thr = (k == 0) ? int'(thr_a) : int'(thr_b);
            if (!rst_n || clr) begin
                m_ticks[k] = 0; m_run[k] = 0; m_tc[k] = 0; m_irq[k] = 0;
            end else begin
                m_irq[k] = 0;
                if (m_tc[k] != 0) begin
                    // frozen until clear
                end else if (m_run[k] != 0) begin
                    if (m_ticks[k] / m_p[k] >= thr) begin
                        m_tc[k] = 1; m_irq[k] = 1;
                    end else if (!en) begin
                        m_run[k] = 0;
                    end else begin
                        m_ticks[k]++;
                    end
                end else if (en) begin
                    m_run[k] = 1;
                end
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_eq("a_val", int'(val_a), m_ticks[0] / m_p[0]);
        check_eq("a_tc",  int'(tc_a),  m_tc[0]);
        check_eq("a_irq", int'(irq_a), m_irq[0]);
        check_eq("b_val", int'(val_b), m_ticks[1] / m_p[1]);
        check_eq("b_tc",  int'(tc_b),  m_tc[1]);
        check_eq("b_irq", int'(irq_b), m_irq[1]);
    endtask

    task automatic pulse_clear();
        clr = 1'b1;
        step();
        clr = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        bit seen;
        int irq_cnt;

        // Reset state
        rst_n = 1'b0;
        step();
        step();
        check_eq("rst_val_a", int'(val_a), 0);
        check_eq("rst_tc_b",  int'(tc_b),  0);
        check_eq("rst_irq_b", int'(irq_b), 0);

        // Basic count on instance A: threshold 5, enable high from edge 0
        rst_n = 1'b1; thr_a = 4'd5; thr_b = 8'd200; en = 1'b1;
        for (int e = 0; e <= 8; e++) begin
            step();
            check_eq("basic_val", int'(val_a), (e < 5) ? e : 5);
            check_eq("basic_tc",  int'(tc_a),  (e >= 6) ? 1 : 0);
            check_eq("basic_irq", int'(irq_a), (e == 6) ? 1 : 0);
        end

        // Clear in DONE with enable high: IDLE next, counting resumes after
        pulse_clear();
        check_eq("clr_val", int'(val_a), 0);
        check_eq("clr_tc",  int'(tc_a),  0);
        irq_cnt = 0;
        for (int e = 0; e < 12; e++) begin
            step();
            if (irq_a) irq_cnt++;
            if (e == 1) check_eq("resume_first_inc", int'(val_a), 1);
        end
        check_eq("one_irq_per_episode", irq_cnt, 1);

        // Threshold 0: terminal count at edge 1
        en = 1'b0;
        pulse_clear();
        thr_a = 4'd0; en = 1'b1;
        step();
        check_eq("thr0_e0_tc", int'(tc_a), 0);
        step();
        check_eq("thr0_e1_tc", int'(tc_a), 1);
        check_eq("thr0_e1_val", int'(val_a), 0);

        // Saturation: WIDTH=4, threshold 15
        en = 1'b0;
        pulse_clear();
        thr_a = 4'd15; en = 1'b1;
        for (int e = 0; e <= 17; e++) begin
            step();
            check_eq("sat_val", int'(val_a), (e < 15) ? e : 15);
            check_eq("sat_tc",  int'(tc_a),  (e >= 16) ? 1 : 0);
        end

        // Threshold lowered from 100 to 3 once B reaches 10
        en = 1'b0;
        pulse_clear();
        thr_b = 8'd100; en = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 80 && !seen; i++) begin
            step();
            if (val_b == 8'd10) seen = 1'b1;
        end
        check_eq("reach10_in_budget", int'(seen), 1);
        thr_b = 8'd3;
        step();
        check_eq("lower_thr_tc",  int'(tc_b),  1);
        check_eq("lower_thr_irq", int'(irq_b), 1);
        check_eq("lower_thr_val", int'(val_b), 10);

        // Prescaled pause on B: threshold 3, enable dropped for 10 cycles
        en = 1'b0;
        pulse_clear();
        thr_b = 8'd3; en = 1'b1;
        for (int e = 0; e <= 5; e++) step();
        check_eq("pause_pre_val", int'(val_b), 1);
        en = 1'b0;
        for (int e = 0; e < 10; e++) begin
            step();
            check_eq("pause_hold_val", int'(val_b), 1);
        end
        en = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            step();
            if (tc_b) seen = 1'b1;
        end
        check_eq("pause_tc_in_budget", int'(seen), 1);
        check_eq("pause_final_val", int'(val_b), 3);

        // Reset mid-count and in DONE
        en = 1'b0;
        pulse_clear();
        thr_a = 4'd12; thr_b = 8'd50; en = 1'b1;
        for (int e = 0; e < 6; e++) step();
        rst_n = 1'b0;
        step();
        check_eq("rst_count_val", int'(val_a), 0);
        check_eq("rst_count_irq", int'(irq_a), 0);
        rst_n = 1'b1; thr_a = 4'd2;
        for (int e = 0; e < 6; e++) step();
        check_eq("pre_rst_done_tc", int'(tc_a), 1);
        rst_n = 1'b0;
        step();
        check_eq("rst_done_tc",  int'(tc_a),  0);
        check_eq("rst_done_irq", int'(irq_a), 0);
        rst_n = 1'b1;

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            rst_n = ($urandom_range(0, 299) != 0);
            clr   = ($urandom_range(0, 49) == 0);
            en    = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 19) == 0) begin
                thr_a = 4'($urandom_range(0, 15));
                thr_b = 8'($urandom_range(0, 30));
            end
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_cnt_core
